mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
//  - Parametrised N-channel memory request arbiter. Multiple requestors (processor
//    fetch/load/store ports, DMA) share one external memory port.
//  - Round-robin arbitration; one outstanding transaction at a time.
//  - Memory side drives the cs/read_req/write_req/addrout/datatomem/datafrommem/
//    mem_resp handshake used by the processor bench. Widths and channel count are generic.
// PARAMETERS
//  NUM_CH       2    number of requestor channels (>=1)
//  DATA_W       16   data width, both directions
//  ADDR_W       14   memory word address width
//  TIMEOUT_CYC  64   ACCESS-state cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1               clock, all logic on posedge
//  reset        in   1               synchronous, active-high reset
//  ch_req       in   NUM_CH          per-channel request; held until ch_gnt
//  ch_we        in   NUM_CH          1=write, 0=read; valid with ch_req
//  ch_addr      in   NUM_CH*ADDR_W   packed per-channel address, ch k at [k*ADDR_W +: ADDR_W]
//  ch_wdata     in   NUM_CH*DATA_W   packed per-channel write data
//  ch_gnt       out  NUM_CH          one-cycle pulse: request accepted and latched
//  ch_done      out  NUM_CH          one-cycle pulse: transaction complete
//  ch_err       out  NUM_CH          one-cycle pulse with ch_done: transaction aborted
//  ch_rdata     out  DATA_W          read data; valid in the ch_done cycle, held until the next done
//  cs           out  1               memory chip select
//  read_req     out  1               memory read strobe
//  write_req    out  1               memory write strobe
//  addrout      out  ADDR_W          memory address
//  datatomem    out  DATA_W          memory write data
//  datafrommem  in   DATA_W          memory read data; sampled when mem_resp=1
//  mem_resp     in   1               memory completion; 1 cycle or longer
// BEHAVIOUR
//  - All outputs are registered. Reset values: all 0, state=IDLE, rr_ptr=0.
//  - FSM states: IDLE -> ACCESS -> RELEASE -> IDLE.
//  - IDLE: if any ch_req, select the first requesting channel at or after rr_ptr, wrapping.
//    Latch addr, wdata, we and owner. Pulse ch_gnt[owner]. Set rr_ptr=(owner+1)%NUM_CH.
//    Go to ACCESS. ch_gnt, cs and the strobe all assert on the same edge.
//  - ACCESS: cs=1. read_req=~we, write_req=we; exactly one strobe is high.
//    addrout/datatomem are stable. Hold until mem_resp=1 is sampled.
//    On mem_resp: capture datafrommem into ch_rdata (read only; write leaves ch_rdata
//    unchanged). Pulse ch_done[owner]. Drop cs and the strobe. Go to RELEASE.
//  - RELEASE: one idle cycle with cs=0 so memory observes deassertion. mem_resp is ignored.
//    Go to IDLE.
//  - Minimum transaction timing: with mem_resp=1 in the first ACCESS cycle, the cycle
//    after the req edge is the gnt cycle, the next is done, the next is RELEASE.
//    A new grant is possible every 3 cycles.
//  - A request is accepted only in IDLE. Requests arriving in other states wait.
//    After ch_gnt, a requestor keeping ch_req high is treated as a new request.
//  - rr_ptr wraps NUM_CH-1 -> 0. With NUM_CH=1 it stays 0 and the channel is always granted.
//  - Simultaneous requests: round-robin only; no fixed priority beyond rr_ptr order.
//  - mem_resp while in IDLE or RELEASE is ignored; no outputs change.
//  - Reset mid-transaction: next edge forces IDLE, cs/strobes=0 and rr_ptr=0.
//    No ch_done or ch_err pulse is produced for the killed transaction.
//  - ch_addr/ch_wdata of a channel may change after its ch_gnt without effect.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - A counter clears on entry to ACCESS and increments each ACCESS cycle without mem_resp.
//    - When it reaches TIMEOUT_CYC: pulse ch_done[owner] and ch_err[owner], force ch_rdata=0,
//      drop cs and the strobe, go to RELEASE.
//    - mem_resp arriving in the same cycle as the timeout wins: normal completion, no error.
//  - MEM_TIMEOUT_EN undefined:
//    - ACCESS waits indefinitely. ch_err is tied to 0. No counter logic is present.
// TESTING
//  1. Single read: ch0 req addr=0x0123, we=0; mem_resp=1 after 2 cycles, datafrommem=0xBEEF
//     -> ch_gnt[0] pulse; cs=1, read_req=1, addrout=0x0123; ch_done[0] pulse; ch_rdata=0xBEEF.
//  2. Single write: ch1 addr=0x3FFF, wdata=0xA55A, we=1; mem_resp after 0 cycles
//     -> write_req=1, datatomem=0xA55A, ch_done[1]; ch_rdata unchanged; RELEASE cycle cs=0.
//  3. Round-robin: NUM_CH=4, all ch_req held high for 8 transactions
//     -> grant order 0,1,2,3,0,1,2,3; each grant 3 cycles apart with immediate mem_resp.
//  4. Reset in ACCESS: ch2 read granted; assert reset before mem_resp
//     -> next edge cs=0, read_req=0; no ch_done; next grant after reset goes to ch0 first.
//  5. Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYC=8): read, mem_resp never asserted
//     -> after 8 ACCESS cycles ch_done and ch_err pulse together, ch_rdata=0x0000, cs drops.
//  6. Stray mem_resp in IDLE with no requests -> all outputs remain 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin N-channel arbiter sharing one memory port, one transaction in flight.
// Optional ACCESS timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_req_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     cs,
    output logic                     read_req,
    output logic                     write_req,
    output logic [ADDR_W-1:0]        addrout,
    output logic [DATA_W-1:0]        datatomem,
    input  logic [DATA_W-1:0]        datafrommem,
    input  logic                     mem_resp
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RELEASE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [PTR_W-1:0]    r_owner, w_owner_nxt;
    logic                r_we, w_we_nxt;
    logic [NUM_CH-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_CH-1:0]   r_done, w_done_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_cs, w_cs_nxt;
    logic                r_rd, w_rd_nxt;
    logic                r_wr, w_wr_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;

    logic                w_any;
    logic                w_hi_any, w_lo_any;
    logic [PTR_W-1:0]    w_hi_sel, w_lo_sel, w_sel;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_timeout;

    // Round-robin pick: first requester at or above rr_ptr, else first requester overall.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_sel = '0;
        w_lo_any = 1'b0;
        w_lo_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_req[k] && !w_lo_any) begin
                w_lo_any = 1'b1;
                w_lo_sel = PTR_W'(k);
            end
            if (ch_req[k] && !w_hi_any && (k >= 32'(r_rr_ptr))) begin
                w_hi_any = 1'b1;
                w_hi_sel = PTR_W'(k);
            end
        end
        w_any = w_lo_any;
        w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_sel == PTR_W'(k)) begin
                w_sel_we    = ch_we[k];
                w_sel_addr  = ch_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata = ch_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]  r_tmo_cnt;
    logic [NUM_CH-1:0] r_err, w_err_nxt;

    // Counter sits at zero outside ACCESS, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_ACCESS)) begin
            r_tmo_cnt <= '0;
        end else if (!mem_resp) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && !mem_resp &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign ch_err    = r_err;
`else
    assign w_timeout = 1'b0;
    assign ch_err    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_state_nxt = S_ACCESS;
            S_ACCESS:  if (mem_resp || w_timeout) w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_rdata_nxt = r_rdata;
        w_cs_nxt    = r_cs;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = r_we;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
`ifdef MEM_TIMEOUT_EN
        w_err_nxt   = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_sel;
                    w_we_nxt    = w_sel_we;
                    w_addr_nxt  = w_sel_addr;
                    w_wdata_nxt = w_sel_wdata;
                    w_gnt_nxt   = NUM_CH'(1) << w_sel;
                    w_cs_nxt    = 1'b1;
                    w_rd_nxt    = ~w_sel_we;
                    w_wr_nxt    = w_sel_we;
                    w_rr_nxt    = (w_sel == PTR_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
                end
            end
            S_ACCESS: begin
                if (mem_resp) begin
                    w_done_nxt = NUM_CH'(1) << r_owner;
                    if (!r_we) w_rdata_nxt = datafrommem;
                    w_cs_nxt   = 1'b0;
                    w_rd_nxt   = 1'b0;
                    w_wr_nxt   = 1'b0;
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_timeout) begin
                    w_done_nxt  = NUM_CH'(1) << r_owner;
                    w_err_nxt   = NUM_CH'(1) << r_owner;
                    w_rdata_nxt = '0;
                    w_cs_nxt    = 1'b0;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_cs     <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
`ifdef MEM_TIMEOUT_EN
            r_err    <= '0;
`endif
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_rdata  <= w_rdata_nxt;
            r_cs     <= w_cs_nxt;
            r_rd     <= w_rd_nxt;
            r_wr     <= w_wr_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
`ifdef MEM_TIMEOUT_EN
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign ch_gnt    = r_gnt;
    assign ch_done   = r_done;
    assign ch_rdata  = r_rdata;
    assign cs        = r_cs;
    assign read_req  = r_rd;
    assign write_req = r_wr;
    assign addrout   = r_addr;
    assign datatomem = r_wdata;

endmodule
